// File: rtl/md_if.sv
// Issue/result bundle between the E stage and the multiply/divide sequencer.
// The E stage (master) issues operations; the sequencer (slave) returns HI/LO and status.
interface md_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;

  modport master (
    output start, mdop, A, B, md_use,
    input  HI, LO, busy, md_stall
  );

  modport slave (
    input  start, mdop, A, B, md_use,
    output HI, LO, busy, md_stall
  );
endinterface

// File: rtl/md_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Operands are latched at issue; HI/LO are written only when the busy countdown expires.
module md_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic             signed_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;

  logic [63:0] prod_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Product and quotient/remainder from the latched operands.
  // Division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
  always_comb begin
    prod_s  = 64'd0;
    a_mag_s = a_r;
    b_mag_s = b_r;
    if (signed_r) begin
      prod_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
      if (a_r[31]) a_mag_s = 32'd0 - a_r; else a_mag_s = a_r;
      if (b_r[31]) b_mag_s = 32'd0 - b_r; else b_mag_s = b_r;
    end else begin
      prod_s = {32'd0, a_r} * {32'd0, b_r};
    end
    if (b_mag_s != 32'd0) begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end else begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end
    if (signed_r && (a_r[31] ^ b_r[31])) quot_s = 32'd0 - q_mag_s; else quot_s = q_mag_s;
    if (signed_r && a_r[31]) rem_s = 32'd0 - r_mag_s; else rem_s = r_mag_s;
  end

  // Sequencer FSM: issue, countdown and HI/LO writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      signed_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            case (bus.mdop)
              3'd0, 3'd1: begin
                a_r      <= bus.A;
                b_r      <= bus.B;
                signed_r <= (bus.mdop == 3'd0);
                cnt_r    <= MULT_LOAD;
                state_r  <= MUL;
                busy_r   <= 1'b1;
              end
              3'd2, 3'd3: begin
                a_r      <= bus.A;
                b_r      <= bus.B;
                signed_r <= (bus.mdop == 3'd2);
                cnt_r    <= DIV_LOAD;
                state_r  <= DIV;
                busy_r   <= 1'b1;
              end
              3'd4:    hi_r <= bus.A;
              3'd5:    lo_r <= bus.A;
              default: state_r <= IDLE;
            endcase
          end
        end
        MUL: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            hi_r    <= prod_s[63:32];
            lo_r    <= prod_s[31:0];
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        DIV: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            // Divide by zero leaves HI/LO untouched.
            if (b_r != 32'd0) begin
              hi_r <= rem_s;
              lo_r <= quot_s;
            end
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HI       = hi_r;
  assign bus.LO       = lo_r;
  assign bus.busy     = busy_r;
  assign bus.md_stall = bus.md_use & (bus.start | busy_r);
endmodule
